// File: rtl/aes_decipher_round.sv
// -----------------------------------------------------------------------------
// aes_decipher_round
//   Iterative AES inverse cipher (InvCipher) for 128- and 256-bit keys.
//   One round takes five cycles. Four cycles push one column word each through
//   the shared external inverse S-box. One cycle does InvShiftRows,
//   AddRoundKey and InvMixColumns together. The last round skips
//   InvMixColumns. Round keys are fetched from the key memory in descending
//   order through the `round` index.
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   next       : start pulse, accepted only while ready=1
//   keylen     : 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14), sampled on start
//   round      : round-key index requested from the key memory
//   round_key  : key for index `round`, combinational from the key memory
//   sboxw      : word sent to the inverse S-box (0 outside S-box cycles)
//   new_sboxw  : InvSubBytes(sboxw), combinational
//   block      : ciphertext, sampled on start
//   new_block  : plaintext, valid while ready=1 after an operation completes
//   ready      : 1 = idle / result valid
// -----------------------------------------------------------------------------
module aes_decipher_round (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    localparam logic AES_128_BIT_KEY = 1'h0;
    localparam logic AES_256_BIT_KEY = 1'h1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SBOX  = 2'd1;
    localparam logic [1:0] MAIN  = 2'd2;
    localparam logic [1:0] FINAL = 2'd3;

    logic [31:0]  w_reg [4];
    logic [3:0]   round_ctr_reg;
    logic [1:0]   sword_ctr_reg;
    logic [1:0]   state_reg;
    logic         ready_reg;
    logic [3:0]   nr_in;
    logic [127:0] ark_w;
    logic [127:0] mix_w;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column. The 09/0b/0d/0e products are built from
    // the x2/x4/x8 doublings of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                me[1] ^ mb[2] ^ md[3] ^ m9[0],
                me[2] ^ mb[3] ^ md[0] ^ m9[1],
                me[3] ^ mb[0] ^ md[1] ^ m9[2]};
    endfunction

    always_comb begin
        case (keylen)
            AES_128_BIT_KEY: nr_in = 4'd10;
            AES_256_BIT_KEY: nr_in = 4'd14;
            default:         nr_in = 4'd10;
        endcase
    end

    // While idle, present the last round key so the initial AddRoundKey can
    // happen on the accepting edge.
    always_comb begin
        round = (state_reg == IDLE) ? nr_in : round_ctr_reg;
    end

    always_comb begin
        sboxw = (state_reg == SBOX) ? w_reg[sword_ctr_reg] : 32'h0;
    end

    // InvShiftRows folded into the AddRoundKey wiring: byte r of column c
    // comes from column (c - r) mod 4. The bytes have already passed through
    // the S-box. This ordering is valid because InvSubBytes and InvShiftRows
    // both work bytewise and commute.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            for (gj = 0; gj < 4; gj++) begin : g_row
                assign ark_w[127 - 32*gi - 8*gj -: 8] =
                    w_reg[(gi - gj + 4) % 4][31 - 8*gj -: 8] ^
                    round_key[127 - 32*gi - 8*gj -: 8];
            end
            assign mix_w[127 - 32*gi -: 32] = inv_mix_col(ark_w[127 - 32*gi -: 32]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                w_reg[i] <= 32'h0;
            end
            round_ctr_reg <= 4'd0;
            sword_ctr_reg <= 2'd0;
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (next) begin
                        for (int i = 0; i < 4; i++) begin
                            w_reg[i] <= block[127 - 32*i -: 32] ^ round_key[127 - 32*i -: 32];
                        end
                        round_ctr_reg <= nr_in - 4'd1;
                        sword_ctr_reg <= 2'd0;
                        ready_reg     <= 1'b0;
                        state_reg     <= SBOX;
                    end
                end
                SBOX: begin
                    w_reg[sword_ctr_reg] <= new_sboxw;
                    sword_ctr_reg        <= sword_ctr_reg + 2'd1;
                    if (sword_ctr_reg == 2'd3) begin
                        state_reg <= (round_ctr_reg != 4'd0) ? MAIN : FINAL;
                    end
                end
                MAIN: begin
                    for (int i = 0; i < 4; i++) begin
                        w_reg[i] <= mix_w[127 - 32*i -: 32];
                    end
                    round_ctr_reg <= round_ctr_reg - 4'd1;
                    state_reg     <= SBOX;
                end
                FINAL: begin
                    for (int i = 0; i < 4; i++) begin
                        w_reg[i] <= ark_w[127 - 32*i -: 32];
                    end
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign new_block = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher_round.sv
// -----------------------------------------------------------------------------
// tb_aes_decipher_round
//   Models the key memory (indexed by `round`) and the inverse S-box around
//   aes_decipher_round. Plaintext is predicted with a byte-matrix InvCipher
//   reference built from GF(2^8) arithmetic. Runs the known-answer vectors,
//   then ignored-start, abort-by-reset, back-to-back and random operations.
// -----------------------------------------------------------------------------
module tb_aes_decipher_round;
    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [255:0][7:0]  sbox_t;
    logic [255:0][7:0]  inv_sbox_t;
    logic [14:0][127:0] rk_mem;

    int n_compared   = 0;
    int n_mismatched = 0;
    int lat;
    int round_log[$];
    int dedup[$];
    logic [127:0] ct_r;
    logic [127:0] pt_r;
    logic [255:0] key_r;
    logic         klen_r;

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    aes_decipher_round dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign round_key = (round <= 4'd14) ? rk_mem[round] : 128'h0;
    assign new_sboxw = {inv_sbox_t[sboxw[31:24]], inv_sbox_t[sboxw[23:16]],
                        inv_sbox_t[sboxw[15:8]],  inv_sbox_t[sboxw[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse (x^254).
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_t[x]     = b;
            inv_sbox_t[b] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [14:0][127:0] expand_key(input logic [255:0] key, input logic klen);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        logic [14:0][127:0] rk = '0;
        int nk = klen ? 8 : 4;
        int nr = klen ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    // State kept as s[column][row]. Each round does InvShiftRows,
    // InvSubBytes, AddRoundKey, then InvMixColumns except in the last round.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct,
                                                 input logic [14:0][127:0] rk,
                                                 input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] st;
        base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        st = ct ^ rk[nr];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    s[c][b] = st[127 - 32*c - 8*b -: 8];
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    t[c][b] = inv_sbox_t[s[(c - b + 4) % 4][b]] ^ rk[r][127 - 32*c - 8*b -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int b = 0; b < 4; b++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - b + 4) % 4], t[c][k]);
                        s[c][b] = acc;
                    end
                for (int c = 0; c < 4; c++)
                    for (int b = 0; b < 4; b++)
                        t[c][b] = s[c][b];
            end
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    st[127 - 32*c - 8*b -: 8] = t[c][b];
        end
        return st;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge. The next edge is the accepting edge.
    task automatic start_op(input logic [127:0] ct, input logic klen, input bit hold);
        block  = ct;
        keylen = klen;
        next   = 1'b1;
        round_log.delete();
        #1;
        round_log.push_back(int'(round));
        @(posedge clk);
        #1;
        if (!hold) next = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until ready, bounded.
    // If pulse_at > 0, a stray start with other data is pulsed mid-operation.
    task automatic wait_done(input int pulse_at, output int l);
        l = 1;
        while (ready !== 1'b1 && l < 200) begin
            round_log.push_back(int'(round));
            @(posedge clk);
            #1;
            l++;
            if (pulse_at > 0 && l == pulse_at) begin
                next   = 1'b1;
                block  = {$urandom, $urandom, $urandom, $urandom};
                keylen = ~keylen;
            end else if (pulse_at > 0 && l == pulse_at + 1) begin
                next = 1'b0;
            end
        end
    endtask

    task automatic run_op(input logic [255:0] key, input logic klen, input logic [127:0] ct,
                          input int pulse_at, output int l);
        rk_mem = expand_key(key, klen);
        start_op(ct, klen, 1'b0);
        wait_done(pulse_at, l);
    endtask

    initial begin
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        rk_mem  = '0;
        build_tables();

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 128'(ready), 128'd1);
        check("reset_new_block", new_block, 128'd0);
        check("reset_sboxw", 128'(sboxw), 128'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", 128'(ready), 128'd1);

        // 1: FIPS-197 appendix B
        run_op(KEY_B, 1'b0, CT_B, 0, lat);
        $display("op t1 aes128 ct=%h pt=%h lat=%0d", CT_B, new_block, lat);
        check("t1_pt", new_block, PT_B);
        check("t1_lat", 128'(lat), 128'd51);
        check("t1_idle_sboxw", 128'(sboxw), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_pt", new_block, PT_B);

        // 2: FIPS-197 C.1
        run_op(KEY_C1, 1'b0, CT_C1, 0, lat);
        $display("op t2 aes128 ct=%h pt=%h lat=%0d", CT_C1, new_block, lat);
        check("t2_pt", new_block, PT_C);
        check("t2_lat", 128'(lat), 128'd51);

        // 3: FIPS-197 C.3, with the round-key index sequence
        run_op(KEY_C3, 1'b1, CT_C3, 0, lat);
        $display("op t3 aes256 ct=%h pt=%h lat=%0d", CT_C3, new_block, lat);
        check("t3_pt", new_block, PT_C);
        check("t3_lat", 128'(lat), 128'd71);
        dedup.delete();
        foreach (round_log[i])
            if (dedup.size() == 0 || dedup[dedup.size()-1] != round_log[i])
                dedup.push_back(round_log[i]);
        check("t3_round_seq_len", 128'(dedup.size()), 128'd15);
        for (int i = 0; i < dedup.size() && i < 15; i++)
            check($sformatf("t3_round_seq[%0d]", i), 128'(dedup[i]), 128'(14 - i));

        // 4: stray start mid-operation is ignored
        run_op(KEY_C1, 1'b0, CT_C1, 20, lat);
        $display("op t4 aes128 stray-start ct=%h pt=%h lat=%0d", CT_C1, new_block, lat);
        check("t4_pt", new_block, PT_C);
        check("t4_lat", 128'(lat), 128'd51);

        // 5: asynchronous reset in the middle of an S-box cycle of round 5
        rk_mem = expand_key(KEY_B, 1'b0);
        start_op(CT_B, 1'b0, 1'b0);
        repeat (21) @(posedge clk);
        #1;
        check("t5_busy_before_abort", 128'(ready), 128'd0);
        reset_n = 1'b0;
        #1;
        $display("op t5 abort ready=%0b new_block=%h", ready, new_block);
        check("t5_abort_ready", 128'(ready), 128'd1);
        check("t5_abort_new_block", new_block, 128'd0);
        check("t5_abort_sboxw", 128'(sboxw), 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_release_ready", 128'(ready), 128'd1);
        run_op(KEY_B, 1'b0, CT_B, 0, lat);
        $display("op t5 rerun ct=%h pt=%h lat=%0d", CT_B, new_block, lat);
        check("t5_rerun_pt", new_block, PT_B);
        check("t5_rerun_lat", 128'(lat), 128'd51);

        // 6: back-to-back with next held high
        rk_mem = expand_key(KEY_B, 1'b0);
        start_op(CT_B, 1'b0, 1'b1);
        wait_done(0, lat);
        $display("op t6a b2b ct=%h pt=%h lat=%0d", CT_B, new_block, lat);
        check("t6a_pt", new_block, PT_B);
        check("t6a_lat", 128'(lat), 128'd51);
        block  = CT_C1;
        rk_mem = expand_key(KEY_C1, 1'b0);
        @(posedge clk);
        #1;
        next = 1'b0;
        check("t6_ready_gap", 128'(ready), 128'd0);
        wait_done(0, lat);
        $display("op t6b b2b ct=%h pt=%h lat=%0d", CT_C1, new_block, lat);
        check("t6b_pt", new_block, PT_C);
        check("t6b_lat", 128'(lat), 128'd51);

        // Random keys, key lengths and ciphertexts against the reference model
        for (int k = 0; k < 6; k++) begin
            key_r  = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
            klen_r = 1'($urandom_range(0, 1));
            ct_r   = {$urandom, $urandom, $urandom, $urandom};
            pt_r   = ref_decrypt(ct_r, expand_key(key_r, klen_r), klen_r ? 14 : 10);
            run_op(key_r, klen_r, ct_r, 0, lat);
            $display("op rnd%0d klen=%0b ct=%h pt=%h lat=%0d", k, klen_r, ct_r, new_block, lat);
            check($sformatf("rnd%0d_pt", k), new_block, pt_r);
            check($sformatf("rnd%0d_lat", k), 128'(lat), klen_r ? 128'd71 : 128'd51);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
